// File: rtl/i2c_reg_target.sv
// I2C target exposing a bank of 8-bit registers.
// Byte after the address sets the pointer; later bytes read/write at it.
module i2c_reg_target #(
   parameter int         REGCOUNT = 12,
   parameter logic [6:0] DEV_ADDR = 7'h42
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic [8*REGCOUNT-1:0] registers_packed,
   output logic                  wr_pulse,
   output logic [7:0]            wr_idx
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_ACK
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(REGCOUNT - 1);

   logic       r_scl_s1, r_scl_s2, r_scl_d;
   logic       r_sda_s1, r_sda_s2, r_sda_d;
   logic       w_scl_rise, w_scl_fall;
   logic       w_start, w_stop;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_bitcnt, w_bitcnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic [7:0] r_ptr, w_ptr_nxt;
   logic       r_ack, w_ack_nxt;
   logic       r_sda_oe, w_sda_oe_nxt;
   logic       r_wr_pulse, w_wr_pulse_nxt;
   logic [7:0] r_wr_idx, w_wr_idx_nxt;
   logic [7:0] r_regs [REGCOUNT];
   logic [7:0] w_regs_nxt [REGCOUNT];

   logic [7:0] w_rx_byte;
   logic [7:0] w_ptr_inc;
   logic       w_ptr_ok;
   logic [7:0] w_rd_cur, w_rd_inc;

   // Pin synchronizers plus one history flop for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_d  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_d  <= 1'b1;
      end else begin
         r_scl_s1 <= scl_in;
         r_scl_s2 <= r_scl_s1;
         r_scl_d  <= r_scl_s2;
         r_sda_s1 <= sda_in;
         r_sda_s2 <= r_sda_s1;
         r_sda_d  <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_d;
   assign w_scl_fall = ~r_scl_s2 & r_scl_d;
   assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
   assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
   assign w_rx_byte  = {r_shift[6:0], r_sda_s2};

   // Pointer arithmetic: wrap at the last register, bound check.
   always_comb begin
      w_ptr_ok  = (r_ptr <= LP_LAST);
      w_ptr_inc = (r_ptr == LP_LAST) ? 8'd0 : r_ptr + 8'd1;
   end

   // Read mux for current and next pointer; empty slots read FF.
   always_comb begin
      w_rd_cur = 8'hFF;
      w_rd_inc = 8'hFF;
      for (int i = 0; i < REGCOUNT; i++) begin
         if (r_ptr == 8'(i))     w_rd_cur = r_regs[i];
         if (w_ptr_inc == 8'(i)) w_rd_inc = r_regs[i];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_bitcnt   <= 4'd0;
         r_shift    <= 8'd0;
         r_ptr      <= 8'd0;
         r_ack      <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_wr_idx   <= 8'd0;
         for (int i = 0; i < REGCOUNT; i++) r_regs[i] <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_bitcnt   <= w_bitcnt_nxt;
         r_shift    <= w_shift_nxt;
         r_ptr      <= w_ptr_nxt;
         r_ack      <= w_ack_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_wr_pulse <= w_wr_pulse_nxt;
         r_wr_idx   <= w_wr_idx_nxt;
         r_regs     <= w_regs_nxt;
      end
   end

   // Protocol FSM: bits in on SCL rise, SDA drive moves on SCL fall.
   always_comb begin
      w_state_nxt    = r_state;
      w_bitcnt_nxt   = r_bitcnt;
      w_shift_nxt    = r_shift;
      w_ptr_nxt      = r_ptr;
      w_ack_nxt      = r_ack;
      w_sda_oe_nxt   = r_sda_oe;
      w_wr_pulse_nxt = 1'b0;
      w_wr_idx_nxt   = r_wr_idx;
      w_regs_nxt     = r_regs;
      if (w_stop) begin
         w_state_nxt  = S_IDLE;
         w_sda_oe_nxt = 1'b0;
      end else if (w_start) begin
         w_state_nxt  = S_ADDR;
         w_bitcnt_nxt = 4'd0;
         w_sda_oe_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt  = w_rx_byte;
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  if (r_shift[7:1] == DEV_ADDR) begin
                     w_state_nxt  = S_ADDR_ACK;
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_state_nxt  = S_IDLE;
                     w_sda_oe_nxt = 1'b0;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_bitcnt_nxt = 4'd0;
                  if (r_shift[0]) begin
                     w_state_nxt  = S_RDATA;
                     w_shift_nxt  = w_rd_cur;
                     w_sda_oe_nxt = ~w_rd_cur[7];
                  end else begin
                     w_state_nxt  = S_PTR;
                     w_sda_oe_nxt = 1'b0;
                  end
               end
            end
            S_PTR: begin
               if (w_scl_rise) begin
                  w_shift_nxt  = w_rx_byte;
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) w_ptr_nxt = w_rx_byte;
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  w_state_nxt  = S_PTR_ACK;
                  w_sda_oe_nxt = 1'b1;
               end
            end
            S_PTR_ACK, S_WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_state_nxt  = S_WDATA;
                  w_bitcnt_nxt = 4'd0;
                  w_sda_oe_nxt = 1'b0;
               end
            end
            S_WDATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt  = w_rx_byte;
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     w_ack_nxt = w_ptr_ok;
                     if (w_ptr_ok) begin
                        for (int i = 0; i < REGCOUNT; i++)
                           if (r_ptr == 8'(i)) w_regs_nxt[i] = w_rx_byte;
                        w_wr_pulse_nxt = 1'b1;
                        w_wr_idx_nxt   = r_ptr;
                        w_ptr_nxt      = w_ptr_inc;
                     end
                  end
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  w_state_nxt  = S_WDATA_ACK;
                  w_sda_oe_nxt = r_ack;
               end
            end
            S_RDATA: begin
               if (w_scl_rise) begin
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_bitcnt == 4'd8) begin
                     w_state_nxt  = S_RDATA_ACK;
                     w_sda_oe_nxt = 1'b0;
                  end else begin
                     w_shift_nxt  = {r_shift[6:0], 1'b0};
                     w_sda_oe_nxt = ~r_shift[6];
                  end
               end
            end
            S_RDATA_ACK: begin
               if (w_scl_rise) begin
                  w_ack_nxt = ~r_sda_s2;
               end else if (w_scl_fall) begin
                  if (r_ack) begin
                     w_state_nxt  = S_RDATA;
                     w_bitcnt_nxt = 4'd0;
                     w_ptr_nxt    = w_ptr_inc;
                     w_shift_nxt  = w_rd_inc;
                     w_sda_oe_nxt = ~w_rd_inc[7];
                  end else begin
                     w_state_nxt  = S_IDLE;
                     w_sda_oe_nxt = 1'b0;
                  end
               end
            end
            default: begin
               w_state_nxt  = S_IDLE;
               w_sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
      assign registers_packed[8*g +: 8] = r_regs[g];
   end

   assign sda_oe   = r_sda_oe;
   assign wr_pulse = r_wr_pulse;
   assign wr_idx   = r_wr_idx;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged master, open-drain SDA.
// Expected register contents kept in a small byte-array model.
module tb_i2c_reg_target;

   logic        clk;
   logic        rst;
   logic        scl;
   logic        m_sda;
   logic        sda_oe;
   logic [95:0] regs_p;
   logic        wr_pulse;
   logic [7:0]  wr_idx;
   wire         sda_line = m_sda & ~sda_oe;

   int          vectors;
   int          miscompares;
   int          n_pulse;
   logic [7:0]  last_idx;
   logic [7:0]  m_regs [12];

   i2c_reg_target #(
      .REGCOUNT(12),
      .DEV_ADDR(7'h42)
   ) dut (
      .clock(clk),
      .reset(rst),
      .scl_in(scl),
      .sda_in(sda_line),
      .sda_oe(sda_oe),
      .registers_packed(regs_p),
      .wr_pulse(wr_pulse),
      .wr_idx(wr_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count committed writes and remember the last index.
   always @(posedge clk) begin
      if (wr_pulse) begin
         n_pulse  <= n_pulse + 1;
         last_idx <= wr_idx;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string tag,
                        input logic [127:0] got,
                        input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] packed_model();
      logic [95:0] v;
      for (int i = 0; i < 12; i++) v[8*i +: 8] = m_regs[i];
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      tick(5);
      m_sda = b;
      tick(5);
      scl = 1'b1;
      tick(5);
      s = sda_line;
      tick(5);
      scl = 1'b0;
   endtask

   task automatic bus_start();
      tick(5);
      m_sda = 1'b1;
      tick(5);
      scl = 1'b1;
      tick(10);
      m_sda = 1'b0;
      tick(10);
      scl = 1'b0;
   endtask

   task automatic bus_stop();
      tick(5);
      m_sda = 1'b0;
      tick(5);
      scl = 1'b1;
      tick(10);
      m_sda = 1'b1;
      tick(10);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         d[i] = s;
      end
      bus_bit(~mack, s);
   endtask

   initial begin
      logic       a;
      logic [3:0] av;
      logic [7:0] d;
      logic       s;
      int         p0;

      vectors     = 0;
      miscompares = 0;
      n_pulse     = 0;
      last_idx    = 8'd0;
      for (int i = 0; i < 12; i++) m_regs[i] = 8'd0;
      rst   = 1'b1;
      scl   = 1'b1;
      m_sda = 1'b1;
      tick(3);
      check("rst_oe", sda_oe, 0);
      check("rst_regs", regs_p, 0);
      check("rst_pulse", wr_pulse, 0);
      check("rst_idx", wr_idx, 0);
      rst = 1'b0;
      tick(5);

      // Single write to register 1.
      p0 = n_pulse;
      bus_start();
      wr_byte(8'h84, av[0]);
      wr_byte(8'h01, av[1]);
      wr_byte(8'h5A, av[2]);
      bus_stop();
      check("w1_acks", av[2:0], 3'b111);
      m_regs[1] = 8'h5A;
      check("w1_regs", regs_p, packed_model());
      check("w1_npulse", n_pulse - p0, 1);
      check("w1_idx", last_idx, 1);
      check("w1_idx_hold", wr_idx, 1);

      // Burst write wrapping from register 11 to 0.
      p0 = n_pulse;
      bus_start();
      wr_byte(8'h84, av[0]);
      wr_byte(8'h0B, av[1]);
      wr_byte(8'h11, av[2]);
      wr_byte(8'h22, av[3]);
      bus_stop();
      check("wrap_acks", av, 4'hF);
      m_regs[11] = 8'h11;
      m_regs[0]  = 8'h22;
      check("wrap_regs", regs_p, packed_model());
      check("wrap_npulse", n_pulse - p0, 2);
      check("wrap_idx", last_idx, 0);

      // Preload 3 and 4, then read back via repeated START.
      bus_start();
      wr_byte(8'h84, av[0]);
      wr_byte(8'h03, av[1]);
      wr_byte(8'hA5, av[2]);
      wr_byte(8'h3C, av[3]);
      bus_stop();
      check("pre_acks", av, 4'hF);
      m_regs[3] = 8'hA5;
      m_regs[4] = 8'h3C;
      p0 = n_pulse;
      bus_start();
      wr_byte(8'h84, av[0]);
      wr_byte(8'h03, av[1]);
      bus_start();
      wr_byte(8'h85, av[2]);
      check("rd_acks", av[2:0], 3'b111);
      rd_byte(1'b1, d);
      check("rd_b1", d, 8'hA5);
      rd_byte(1'b0, d);
      check("rd_b2", d, 8'h3C);
      tick(5);
      check("rd_nack_oe", sda_oe, 0);
      bus_stop();
      check("rd_regs", regs_p, packed_model());
      check("rd_npulse", n_pulse - p0, 0);

      // Read across the wrap point: 11 then 0.
      bus_start();
      wr_byte(8'h84, a);
      wr_byte(8'h0B, a);
      bus_start();
      wr_byte(8'h85, a);
      rd_byte(1'b1, d);
      check("rdw_b1", d, 8'h11);
      rd_byte(1'b0, d);
      check("rdw_b2", d, 8'h22);
      bus_stop();

      // Foreign address: no ACK, following bytes ignored.
      p0 = n_pulse;
      bus_start();
      wr_byte(8'h86, a);
      check("nomatch_ack", a, 0);
      wr_byte(8'h01, a);
      check("nomatch_b2", a, 0);
      wr_byte(8'h99, a);
      check("nomatch_b3", a, 0);
      bus_stop();
      check("nomatch_regs", regs_p, packed_model());
      check("nomatch_np", n_pulse - p0, 0);

      // Pointer out of range: data NACKed, nothing written.
      p0 = n_pulse;
      bus_start();
      wr_byte(8'h84, av[0]);
      wr_byte(8'h20, av[1]);
      wr_byte(8'h77, av[2]);
      bus_stop();
      check("oor_acks", av[2:0], 3'b011);
      bus_start();
      wr_byte(8'h84, av[0]);
      wr_byte(8'h0C, av[1]);
      wr_byte(8'h55, av[2]);
      bus_stop();
      check("oor12_acks", av[2:0], 3'b011);
      check("oor_regs", regs_p, packed_model());
      check("oor_npulse", n_pulse - p0, 0);

      // Out-of-range read returns FF.
      bus_start();
      wr_byte(8'h84, a);
      wr_byte(8'h20, a);
      bus_start();
      wr_byte(8'h85, a);
      check("oor_rd_ack", a, 1);
      rd_byte(1'b0, d);
      check("oor_rd", d, 8'hFF);
      bus_stop();

      // Reset during the 5th bit of a data byte.
      p0 = n_pulse;
      bus_start();
      wr_byte(8'h84, a);
      wr_byte(8'h02, a);
      for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
      tick(5);
      m_sda = 1'b0;
      tick(5);
      scl = 1'b1;
      tick(3);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) m_regs[i] = 8'd0;
      check("mid_rst_oe", sda_oe, 0);
      check("mid_rst_regs", regs_p, 0);
      tick(2);
      check("mid_rst_np", n_pulse - p0, 0);
      m_sda = 1'b1;
      tick(5);
      rst = 1'b0;
      tick(10);

      // Fresh transfer after reset.
      p0 = n_pulse;
      bus_start();
      wr_byte(8'h84, av[0]);
      wr_byte(8'h05, av[1]);
      wr_byte(8'h99, av[2]);
      bus_stop();
      check("post_acks", av[2:0], 3'b111);
      m_regs[5] = 8'h99;
      check("post_regs", regs_p, packed_model());
      check("post_np", n_pulse - p0, 1);
      check("post_idx", last_idx, 5);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
